// File: rtl/mac_array_if.sv
// Operand/result handshake bundle for mac_array_nxn.
// The master drives operands and consumes results; the slave is the MAC array.
interface mac_array_if #(
  parameter int N  = 3,
  parameter int DW = 4,
  parameter int AW = 10
);
  localparam int IW = $clog2(N * N);

  logic            start;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] w_vec;
  logic [N*DW-1:0] x_vec;
  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   out_data;
  logic [IW-1:0]   out_idx;
  logic            busy;
  logic            done;
  logic            overflow;

  modport master (
    output start, in_valid, w_vec, x_vec, out_ready,
    input  in_ready, out_valid, out_data, out_idx, busy, done, overflow
  );

  modport slave (
    input  start, in_valid, w_vec, x_vec, out_ready,
    output in_ready, out_valid, out_data, out_idx, busy, done, overflow
  );
endinterface

// File: rtl/mac_array_nxn.sv
// N x N saturating MAC array: accumulates N outer products w*x^T, then streams
// the N*N results row-major over a valid/ready handshake.
module mac_array_nxn #(
  parameter int N  = 3,
  parameter int DW = 4,
  parameter int AW = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  mac_array_if.slave   bus
);
  localparam int NC = N * N;
  localparam int IW = $clog2(NC);
  localparam int CW = $clog2(N + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NC - 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic [AW-1:0]   acc_r [NC];
  logic [AW:0]     cell_s [NC];
  logic            any_sat_s;
  logic [CW-1:0]   beat_cnt_r;
  logic [IW-1:0]   idx_r;
  logic [IW-1:0]   idx_inc_s;
  logic [AW-1:0]   out_data_r;
  logic            in_ready_r;
  logic            out_valid_r;
  logic            busy_r;
  logic            done_r;
  logic            overflow_r;
  logic            in_ready_nx_s;
  logic            busy_nx_s;
  logic            start_s;
  logic            accept_s;
  logic            last_beat_s;
  logic            out_fire_s;
  logic            last_out_s;

  // Bit AW of the result flags saturation; the low AW bits are the clamped sum.
  function automatic logic [AW:0] mac_cell(
    input logic [AW-1:0] acc,
    input logic [DW-1:0] w,
    input logic [DW-1:0] x
  );
    logic [2*DW-1:0] prod;
    logic [AW:0]     sum;
    prod = {{DW{1'b0}}, w} * {{DW{1'b0}}, x};
    sum  = {1'b0, acc} + {{(AW + 1 - 2*DW){1'b0}}, prod};
    if (sum[AW]) begin
      mac_cell = {1'b1, {AW{1'b1}}};
    end else begin
      mac_cell = sum;
    end
  endfunction

  assign start_s     = (state_r == IDLE) && bus.start;
  assign accept_s    = bus.in_valid && in_ready_r;
  assign last_beat_s = accept_s && (beat_cnt_r == LAST_BEAT);
  assign out_fire_s  = out_valid_r && bus.out_ready;
  assign last_out_s  = out_fire_s && (idx_r == LAST_IDX);
  assign idx_inc_s   = idx_r + IW'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    if (start_s)     state_nx_s = LOAD;  else state_nx_s = IDLE;
      LOAD:    if (last_beat_s) state_nx_s = DRAIN; else state_nx_s = LOAD;
      DRAIN:   if (last_out_s)  state_nx_s = IDLE;  else state_nx_s = DRAIN;
      default: state_nx_s = IDLE;
    endcase
  end

  // Output decode from the next state so the flags are registered yet cycle-exact
  always_comb begin
    in_ready_nx_s = 1'b0;
    busy_nx_s     = 1'b0;
    case (state_nx_s)
      IDLE:    begin in_ready_nx_s = 1'b0; busy_nx_s = 1'b0; end
      LOAD:    begin in_ready_nx_s = 1'b1; busy_nx_s = 1'b1; end
      DRAIN:   begin in_ready_nx_s = 1'b0; busy_nx_s = 1'b1; end
      default: begin in_ready_nx_s = 1'b0; busy_nx_s = 1'b0; end
    endcase
  end

  // Per-cell multiply-accumulate candidates for the current beat
  always_comb begin
    any_sat_s = 1'b0;
    for (int k = 0; k < NC; k++) begin
      cell_s[k] = mac_cell(acc_r[k], bus.w_vec[(k / N)*DW +: DW], bus.x_vec[(k % N)*DW +: DW]);
      any_sat_s = any_sat_s | cell_s[k][AW];
    end
  end

  // Accumulators, beat counter and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NC; k++) acc_r[k] <= {AW{1'b0}};
      beat_cnt_r <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else if (start_s) begin
      for (int k = 0; k < NC; k++) acc_r[k] <= {AW{1'b0}};
      beat_cnt_r <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else if (accept_s) begin
      for (int k = 0; k < NC; k++) acc_r[k] <= cell_s[k][AW-1:0];
      beat_cnt_r <= last_beat_s ? {CW{1'b0}} : beat_cnt_r + CW'(1);
      overflow_r <= overflow_r | any_sat_s;
    end else begin
      beat_cnt_r <= beat_cnt_r;
      overflow_r <= overflow_r;
    end
  end

  // Result stream: element 0 is captured from the final beat's sums directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      out_valid_r <= 1'b0;
      idx_r       <= {IW{1'b0}};
      out_data_r  <= {AW{1'b0}};
    end else begin
      in_ready_r <= in_ready_nx_s;
      busy_r     <= busy_nx_s;
      done_r     <= last_out_s;
      if (last_beat_s) begin
        out_valid_r <= 1'b1;
        idx_r       <= {IW{1'b0}};
        out_data_r  <= cell_s[0][AW-1:0];
      end else if (last_out_s) begin
        out_valid_r <= 1'b0;
        idx_r       <= {IW{1'b0}};
        out_data_r  <= {AW{1'b0}};
      end else if (out_fire_s) begin
        out_valid_r <= 1'b1;
        idx_r       <= idx_inc_s;
        out_data_r  <= acc_r[idx_inc_s];
      end else begin
        out_valid_r <= out_valid_r;
        idx_r       <= idx_r;
        out_data_r  <= out_data_r;
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_idx   = idx_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_mac_array_nxn.sv
// Directed bench for mac_array_nxn: an AW=10 instance plus an AW=9 twin that
// shares every input, so the saturating case can be observed side by side.
module tb_mac_array_nxn;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [9:0] exp_d [9];

  mac_array_if #(.N(3), .DW(4), .AW(10)) b10 ();
  mac_array_if #(.N(3), .DW(4), .AW(9))  b9 ();

  mac_array_nxn #(.N(3), .DW(4), .AW(10)) u10 (.clk(clk), .rst_n(rst_n), .bus(b10));
  mac_array_nxn #(.N(3), .DW(4), .AW(9))  u9  (.clk(clk), .rst_n(rst_n), .bus(b9));

  assign b9.start     = b10.start;
  assign b9.in_valid  = b10.in_valid;
  assign b9.w_vec     = b10.w_vec;
  assign b9.x_vec     = b10.x_vec;
  assign b9.out_ready = b10.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic do_start(input logic with_beat);
    b10.start    = 1'b1;
    b10.in_valid = with_beat;
    b10.w_vec    = 12'hFFF;
    b10.x_vec    = 12'hFFF;
    tick();
    b10.start    = 1'b0;
    b10.in_valid = 1'b0;
    chk("in_ready_load", b10.in_ready, 1);
    chk("busy_load", b10.busy, 1);
  endtask

  task automatic beat(input logic [11:0] w, input logic [11:0] x);
    b10.in_valid = 1'b1;
    b10.w_vec    = w;
    b10.x_vec    = x;
    tick();
    b10.in_valid = 1'b0;
  endtask

  task automatic beats_ident();
    beat(12'h001, 12'h321);
    beat(12'h010, 12'h654);
    beat(12'h100, 12'h987);
  endtask

  // Streams with out_ready high; optionally pulses start at one index and checks the AW=9 twin.
  task automatic drain(input bit chk9, input logic [8:0] e9, input int start_at);
    for (int k = 0; k < 9; k++) begin
      b10.start = (k == start_at);
      chk($sformatf("out_valid_%0d", k), b10.out_valid, 1);
      chk($sformatf("out_idx_%0d", k), b10.out_idx, k);
      chk($sformatf("out_data_%0d", k), b10.out_data, exp_d[k]);
      if (chk9) chk($sformatf("out_data9_%0d", k), b9.out_data, e9);
      tick();
    end
    b10.start = 1'b0;
    chk("out_valid_end", b10.out_valid, 0);
    chk("done_pulse", b10.done, 1);
    chk("busy_end", b10.busy, 0);
    tick();
    chk("done_clear", b10.done, 0);
    chk("busy_idle", b10.busy, 0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    b10.start     = 1'b0;
    b10.in_valid  = 1'b0;
    b10.w_vec     = 12'h000;
    b10.x_vec     = 12'h000;
    b10.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", b10.in_ready, 0);
    chk("rst_out_valid", b10.out_valid, 0);
    chk("rst_busy", b10.busy, 0);
    chk("rst_done", b10.done, 0);
    chk("rst_overflow", b10.overflow, 0);
    chk("rst_out_data", b10.out_data, 0);
    chk("rst_out_idx", b10.out_idx, 0);
    rst_n = 1'b1;
    tick();

    // Identity W; the start cycle also carries a beat that must be ignored
    do_start(1'b1);
    beats_ident();
    exp_d = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8, 10'd9};
    drain(1'b0, 9'd0, -1);
    chk("ovf_ident", b10.overflow, 0);

    // All operands 15: 675 fits AW=10, saturates to 511 at AW=9
    do_start(1'b0);
    beat(12'hFFF, 12'hFFF);
    beat(12'hFFF, 12'hFFF);
    beat(12'hFFF, 12'hFFF);
    exp_d = '{10'd675, 10'd675, 10'd675, 10'd675, 10'd675, 10'd675, 10'd675, 10'd675, 10'd675};
    drain(1'b1, 9'd511, -1);
    chk("ovf_aw10", b10.overflow, 0);
    chk("ovf_aw9", b9.overflow, 1);

    // out_ready 1-0-0-1 backpressure
    do_start(1'b0);
    chk("ovf_cleared", b9.overflow, 0);
    beats_ident();
    exp_d = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8, 10'd9};
    begin
      int k;
      int cyc;
      k   = 0;
      cyc = 0;
      while (k < 9 && cyc < 40) begin
        b10.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        chk("stall_valid", b10.out_valid, 1);
        chk($sformatf("stall_idx_%0d", cyc), b10.out_idx, k);
        chk($sformatf("stall_data_%0d", cyc), b10.out_data, exp_d[k]);
        tick();
        if (b10.out_ready) k++;
        cyc++;
      end
      b10.out_ready = 1'b1;
      chk("stall_count", k, 9);
      chk("stall_done", b10.done, 1);
      chk("stall_valid_end", b10.out_valid, 0);
      tick();
    end

    // Gapped in_valid: invalid cycles carry poison data
    do_start(1'b0);
    beat(12'h111, 12'h111);
    b10.w_vec = 12'hFFF; b10.x_vec = 12'hFFF; tick();
    beat(12'h111, 12'h111);
    b10.w_vec = 12'hFFF; b10.x_vec = 12'hFFF; tick();
    chk("gap_no_valid", b10.out_valid, 0);
    chk("gap_in_ready", b10.in_ready, 1);
    beat(12'h111, 12'h111);
    chk("gap_valid_next", b10.out_valid, 1);
    chk("gap_in_ready_off", b10.in_ready, 0);
    exp_d = '{10'd3, 10'd3, 10'd3, 10'd3, 10'd3, 10'd3, 10'd3, 10'd3, 10'd3};
    drain(1'b0, 9'd0, -1);

    // Reset mid-LOAD after two beats
    do_start(1'b0);
    beat(12'hFFF, 12'hFFF);
    beat(12'hFFF, 12'hFFF);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", b10.in_ready, 0);
    chk("mid_rst_busy", b10.busy, 0);
    chk("mid_rst_valid", b10.out_valid, 0);
    chk("mid_rst_data", b10.out_data, 0);
    chk("mid_rst_idx", b10.out_idx, 0);
    chk("mid_rst_done", b10.done, 0);
    chk("mid_rst_ovf", b10.overflow, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_valid", b10.out_valid, 0);
    chk("post_rst_busy", b10.busy, 0);
    do_start(1'b0);
    beat(12'h111, 12'h111);
    beat(12'h111, 12'h111);
    beat(12'h111, 12'h111);
    drain(1'b0, 9'd0, -1);

    // start pulsed during DRAIN is ignored
    do_start(1'b0);
    beats_ident();
    exp_d = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8, 10'd9};
    drain(1'b0, 9'd0, 4);
    chk("post_drain_in_ready", b10.in_ready, 0);
    chk("post_drain_valid", b10.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_array_nxn.md
MAC_ARRAY_NXN -- requirements
Module: mac_array_nxn

Interface
REQ-001 SHALL have parameter N, default 3: array dimension; N x N MAC cells; legal range 2..8.
REQ-002 SHALL have parameter DW, default 4: unsigned operand width.
REQ-003 SHALL have parameter AW, default 10: accumulator and result width; AW >= 2*DW.
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1: begin a job; sampled only in IDLE.
REQ-007 SHALL have port in_valid, input, 1: operand beat valid.
REQ-008 SHALL have port in_ready, output, 1: operand beat accepted when in_valid && in_ready.
REQ-009 SHALL have port w_vec, input, N*DW: column k of W; element i at bits [i*DW +: DW].
REQ-010 SHALL have port x_vec, input, N*DW: row k of X; element j at bits [j*DW +: DW].
REQ-011 SHALL have port out_valid, output, 1: result beat valid.
REQ-012 SHALL have port out_ready, input, 1: result beat consumed when out_valid && out_ready.
REQ-013 SHALL have port out_data, output, AW: result element C[i][j].
REQ-014 SHALL have port out_idx, output, clog2(N*N): row-major index i*N+j of out_data.
REQ-015 SHALL have port busy, output, 1: high in LOAD or DRAIN.
REQ-016 SHALL have port done, output, 1: one-cycle pulse after the last result beat is consumed.
REQ-017 SHALL have port overflow, output, 1: sticky; some accumulator saturated in the current or last job.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, DRAIN.
REQ-019 IDLE -> LOAD on start: all N*N accumulators, beat counter and overflow cleared in that same edge.
REQ-020 In LOAD, in_ready = 1; in IDLE and DRAIN, in_ready = 0; in_valid outside LOAD ignored.
REQ-021 Each accepted beat SHALL update every cell: acc[i][j] <= acc[i][j] + w_vec[i]*x_vec[j], products full 2*DW width, zero-extended to AW.
REQ-022 Sum exceeding 2^AW-1 SHALL clamp to 2^AW-1 and set overflow; a clamped cell stays at max.
REQ-023 LOAD -> DRAIN on the edge accepting the N-th beat; in_valid low cycles SHALL not advance the counter.
REQ-024 out_valid SHALL assert the cycle after DRAIN entry (one cycle after last accept), starting at idx 0.
REQ-025 Results SHALL be streamed row-major, idx 0..N*N-1, one per handshake; idx advances only on out_valid && out_ready.
REQ-026 While out_valid && !out_ready, out_data and out_idx SHALL hold stable.
REQ-027 On handshake of idx N*N-1: DRAIN -> IDLE, out_valid low next cycle, done = 1 for exactly that next cycle.
REQ-028 start while busy SHALL be ignored with no effect on state or data.
REQ-029 start and in_valid both high in IDLE: only start takes effect; the beat is not accepted.
REQ-030 Accumulators SHALL hold their final values in IDLE until the next start; overflow holds until next start.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, accumulators 0, counters 0, in_ready 0, out_valid 0, out_data 0, out_idx 0, busy 0, done 0, overflow 0.
REQ-032 Reset mid-LOAD or mid-DRAIN SHALL abandon the job; after release, no out_valid until a new start plus N beats.
REQ-033 Release of rst_n SHALL be registered on clk; first start honoured on the first rising edge with rst_n high.

Verification
REQ-034 N=3, DW=4, AW=10; W = identity, X = [[1,2,3],[4,5,6],[7,8,9]], out_ready=1 -> out_data 1,2,3,4,5,6,7,8,9 at idx 0..8, done pulse one cycle after idx 8, overflow 0.
REQ-035 All operands 15, AW=10 -> nine results of 675, overflow 0; same with AW=9 -> nine results of 511, overflow 1.
REQ-036 out_ready toggling 1-0-0-1 during DRAIN -> no duplicated or skipped idx; out_data stable across stall cycles.
REQ-037 in_valid gapped (1,0,1,0,1) in LOAD -> exactly 3 beats accepted; first out_valid one cycle after third accept.
REQ-038 rst_n pulsed low after 2 beats -> all outputs 0 immediately; start then 3 beats of ones -> nine results of 3.
REQ-039 start asserted during DRAIN -> ignored; stream completes unchanged, state returns to IDLE.
